// File: rtl/pb_debounce_pkg.sv
// Shared types and constants for the multi-channel pushbutton debouncer.
// Holds the per-channel hold-FSM state encoding and the released-level helpers.
package pb_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_e;

  // Raw PB level of a released button: high for active-low wiring, low otherwise.
  function automatic logic pb_released_level(input logic active_low);
    return active_low;
  endfunction

  // Level the synchroniser holds for a released button once polarity is folded in.
  function automatic logic sync_released_level(input logic active_low);
    return pb_released_level(active_low) ^ active_low;
  endfunction

endpackage

// File: rtl/pb_debounce_ch.sv
// One pushbutton channel: 2-flop synchroniser, mismatch debounce counter,
// hold FSM (IDLE/HELD/LONG) driven by the shared tick, and registered pulses.
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int CNT_W        = 10,
  parameter int ACTIVE_LOW   = 1,
  parameter int HOLD_W       = 8,
  parameter int LONG_TICKS   = 64,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pb,
  input  logic i_tick,
  output logic o_state,
  output logic o_down,
  output logic o_up,
  output logic o_long,
  output logic o_rpt
);

  localparam logic              ACT_LOW       = (ACTIVE_LOW != 0);
  localparam logic              RPT_ON        = (REPEAT_EN != 0);
  localparam logic              SYNC_RELEASED = sync_released_level(ACT_LOW);
  localparam int                RPT_W         = $clog2(REPEAT_TICKS + 1);
  localparam logic [HOLD_W-1:0] LONG_M1       = HOLD_W'(LONG_TICKS - 1);
  localparam logic [RPT_W-1:0]  RPT_M1        = RPT_W'(REPEAT_TICKS - 1);

  logic              r_sync0;
  logic              r_sync1;
  logic              r_db;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_state;
  logic              r_down;
  logic              r_up;
  logic              r_long;
  logic              r_rpt;
  logic [HOLD_W-1:0] r_hold;
  logic [RPT_W-1:0]  r_rpt_cnt;
  hold_state_e       r_hstate;
  hold_state_e       w_hstate_next;

  logic w_press;
  logic w_release;
  logic w_long_hit;
  logic w_rpt_hit;
  logic w_long_fire;
  logic w_rpt_fire;

  // r_db is the internal debounced level; r_state is its registered copy, so the
  // cycle where they differ is exactly the press/release event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= SYNC_RELEASED;
      r_sync1 <= SYNC_RELEASED;
      r_cnt   <= '0;
      r_db    <= 1'b0;
    end else begin
      r_sync0 <= i_pb ^ ACT_LOW;
      r_sync1 <= r_sync0;
      if (r_db == r_sync1) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) r_db <= ~r_db;
      end
    end
  end

  assign w_press    = r_db & ~r_state;
  assign w_release  = ~r_db & r_state;
  assign w_long_hit = (r_hstate == HELD) && i_tick && (r_hold == LONG_M1);
  assign w_rpt_hit  = RPT_ON && (r_hstate == LONG) && i_tick && (r_rpt_cnt == RPT_M1);

  always_ff @(posedge clk) begin
    if (rst) r_hstate <= IDLE;
    else     r_hstate <= w_hstate_next;
  end

  always_comb begin
    w_hstate_next = r_hstate;
    case (r_hstate)
      IDLE:    if (w_press) w_hstate_next = HELD;
      HELD: begin
        if (w_release)       w_hstate_next = IDLE;
        else if (w_long_hit) w_hstate_next = LONG;
      end
      LONG:    if (w_release) w_hstate_next = IDLE;
      default: w_hstate_next = IDLE;
    endcase
  end

  // A release on the same edge wins over any long/repeat pulse that was due.
  always_comb begin
    w_long_fire = w_long_hit & ~w_release;
    w_rpt_fire  = w_rpt_hit & ~w_release;
  end

  always_ff @(posedge clk) begin
    if (rst || w_release || (r_hstate == IDLE)) begin
      r_hold    <= '0;
      r_rpt_cnt <= '0;
    end else begin
      if (i_tick && !(&r_hold)) r_hold <= r_hold + 1'b1;
      if (r_hstate == LONG && RPT_ON && i_tick) begin
        if (r_rpt_cnt == RPT_M1) r_rpt_cnt <= '0;
        else                     r_rpt_cnt <= r_rpt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= 1'b0;
      r_down  <= 1'b0;
      r_up    <= 1'b0;
      r_long  <= 1'b0;
      r_rpt   <= 1'b0;
    end else begin
      r_state <= r_db;
      r_down  <= w_press;
      r_up    <= w_release;
      r_long  <= w_long_fire;
      r_rpt   <= w_rpt_fire;
    end
  end

  assign o_state = r_state;
  assign o_down  = r_down;
  assign o_up    = r_up;
  assign o_long  = r_long;
  assign o_rpt   = r_rpt;

endmodule

// File: rtl/pb_debouncer_multi.sv
// Multi-channel pushbutton debouncer: one shared tick prescaler feeding
// N_CH independent debounce/hold channels.
module pb_debouncer_multi
  import pb_debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 10,
  parameter int ACTIVE_LOW   = 1,
  parameter int HOLD_W       = 8,
  parameter int LONG_TICKS   = 64,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_TICKS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] PB,
  output logic [N_CH-1:0] PB_state,
  output logic [N_CH-1:0] PB_down,
  output logic [N_CH-1:0] PB_up,
  output logic [N_CH-1:0] PB_long,
  output logic [N_CH-1:0] PB_rpt
);

  logic [CNT_W-1:0] r_presc;
  logic             w_tick;

  always_ff @(posedge clk) begin
    if (rst) r_presc <= '0;
    else     r_presc <= r_presc + 1'b1;
  end

  assign w_tick = &r_presc;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      pb_debounce_ch #(
        .CNT_W        (CNT_W),
        .ACTIVE_LOW   (ACTIVE_LOW),
        .HOLD_W       (HOLD_W),
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_EN    (REPEAT_EN),
        .REPEAT_TICKS (REPEAT_TICKS)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .i_pb    (PB[gi]),
        .i_tick  (w_tick),
        .o_state (PB_state[gi]),
        .o_down  (PB_down[gi]),
        .o_up    (PB_up[gi]),
        .o_long  (PB_long[gi]),
        .o_rpt   (PB_rpt[gi])
      );
    end
  endgenerate

endmodule
